// File: rtl/fifo_burst_reader_pkg.sv
// rtl/fifo_burst_reader_pkg.sv - shared types and defaults for the FIFO burst reader
package fifo_burst_reader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port, downstream stream and control bundle
interface fifo_burst_reader_if #(
    parameter int DATA_W = fifo_burst_reader_pkg::DEF_DATA_W,
    parameter int CNT_W  = fifo_burst_reader_pkg::DEF_CNT_W
);
    logic [DATA_W-1:0] buf_out;
    logic              buf_empty;
    logic [CNT_W-1:0]  fifo_counter;
    logic              rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              flush;
    logic              busy;

    modport master (
        input  buf_out, buf_empty, fifo_counter, m_ready, flush,
        output rd_en, m_data, m_valid, m_last, busy
    );

    modport slave (
        output buf_out, buf_empty, fifo_counter, m_ready, flush,
        input  rd_en, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// rtl/fifo_burst_reader_skid_buf.sv - 2-entry output buffer between FIFO read data and the stream
module fifo_burst_reader_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);
    logic [DATA_W-1:0] data_q [2];
    logic              last_q [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        cnt;

    // Ring of two entries; the issuer guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ        = cnt;
    assign head_valid = (cnt != 2'd0);
    assign head_data  = data_q[rd_ptr];
    assign head_last  = head_valid && last_q[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains the dual-clock FIFO in bursts onto a valid/ready stream
module fifo_burst_reader import fifo_burst_reader_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk_r,
    input  logic                rst,
    fifo_burst_reader_if.master bus
);
    localparam int               TMR_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] TMR_FIRE    = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX     = TMR_W'(TIMEOUT);

    state_t            state;
    state_t            state_nx;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  delivered;
    logic [CNT_W-1:0]  start_len;
    logic              start;
    logic              rd_en;
    logic              inflight;
    logic              inflight_last;
    logic              pop;
    logic [1:0]        occ;
    logic              head_valid;
    logic              head_last;
    logic [DATA_W-1:0] head_data;

    assign pop = head_valid && bus.m_ready;

    // Burst decision, read issue and completion; rd_en is held off while reset is asserted.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        start_len = '0;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.fifo_counter >= BURST_LEN_C) begin
                    start_len = BURST_LEN_C;
                    start     = 1'b1;
                end else if (bus.flush || (!bus.buf_empty && timer >= TMR_FIRE)) begin
                    // Counter is below BURST_LEN on this path, so it is already the min.
                    start_len = bus.fifo_counter;
                    start     = (bus.fifo_counter != '0);
                end
                if (start) begin
                    state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (issued == len) begin
                    state_nx = S_FINISH;
                end else begin
                    rd_en = !rst && !bus.buf_empty &&
                            (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
                end
            end
            S_FINISH: begin
                if (!inflight && occ == 2'd0 && delivered == len) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Backlog age: counts non-empty idle cycles, saturating; >= keeps a lagging counter from stranding data.
    always_ff @(posedge clk_r) begin
        if (rst || start || state != S_IDLE || bus.buf_empty) begin
            timer <= '0;
        end else if (timer != TMR_MAX) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Per-burst issue/delivery counters and the one-cycle read pipeline tag.
    always_ff @(posedge clk_r) begin
        if (rst) begin
            len           <= '0;
            issued        <= '0;
            delivered     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && (issued == len - CNT_W'(1));
            if (start) begin
                len       <= start_len;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (rd_en) begin
                    issued <= issued + CNT_W'(1);
                end
                if (pop) begin
                    delivered <= delivered + CNT_W'(1);
                end
            end
        end
    end

    fifo_burst_reader_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk_r),
        .rst        (rst),
        .push       (inflight),
        .push_data  (bus.buf_out),
        .push_last  (inflight_last),
        .pop        (pop),
        .occ        (occ),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_last  (head_last)
    );

    assign bus.rd_en   = rd_en;
    assign bus.m_data  = head_data;
    assign bus.m_valid = head_valid;
    assign bus.m_last  = head_last;
    assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int CW = 7;
    localparam int BL = 8;
    localparam int TO = 16;

    logic clk_r = 1'b0;
    logic rst;
    always #5 clk_r = ~clk_r;

    fifo_burst_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fifo_burst_reader #(.DATA_W(DW), .CNT_W(CW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk_r (clk_r),
        .rst   (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];
    bit            exp_last[$];
    int            cnt_ovr = -1;
    bit            flush_r = 1'b0;
    bit            ready_r = 1'b1;

    bit            m_busy = 1'b0;
    int            m_timer = 0;
    int            m_len = 0;
    int            m_issued = 0;
    int            fin_cnt = 0;
    int            start_cyc = -100;

    bit            prev_rd = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    bit            prev_last;
    logic [DW-1:0] nxt_out;
    bit            nxt_out_v = 1'b0;

    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int            got_cyc[$];
    int            rd_cycles[$];
    logic [DW-1:0] want[$];

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.buf_empty    = (fq.size() == 0);
        bus.fifo_counter = CW'((cnt_ovr >= 0) ? cnt_ovr : fq.size());
        bus.buf_out      = nxt_out_v ? nxt_out : DW'($urandom);
        bus.flush        = flush_r;
        bus.m_ready      = ready_r;
    endtask

    // Per-cycle compare against the behavioural model, then advance the FIFO and model.
    task automatic cycle_check();
        bit exp_v, exp_pop, exp_rd, pop, was_idle, l;
        int n, ln;
        logic [DW-1:0] d;
        if (rst) begin
            chk_eq("rd_en_in_reset", bus.rd_en, 0);
            m_busy = 0; m_timer = 0; fin_cnt = 0; m_issued = 0; m_len = 0;
            exp_last.delete(); pend.delete();
            prev_rd = 0; prev_stall = 0; nxt_out_v = 0; start_cyc = -100;
            cyc++;
            return;
        end
        n       = int'(bus.fifo_counter);
        exp_v   = (pend.size() - (prev_rd ? 1 : 0)) > 0;
        exp_pop = exp_v && ready_r;
        exp_rd  = m_busy && (m_issued < m_len) && !bus.buf_empty &&
                  ((pend.size() - (exp_pop ? 1 : 0)) < 2);
        chk_eq("m_valid", bus.m_valid, exp_v);
        chk_eq("busy", bus.busy, m_busy);
        chk_eq("rd_en", bus.rd_en, exp_rd);
        if (bus.rd_en && bus.buf_empty) chk_eq("rd_en_while_empty", bus.rd_en, 0);
        if (prev_stall) begin
            chk_eq("stall_valid", bus.m_valid, 1);
            chk_eq("stall_data", bus.m_data, prev_data);
            chk_eq("stall_last", bus.m_last, prev_last);
        end
        if (cyc == start_cyc + 2) chk_eq("first_valid_latency", bus.m_valid, 1);
        pop = bus.m_valid && bus.m_ready;
        l = 0;
        if (pop) begin
            if (exp_last.size() == 0 || pend.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_transfer: got data %0h with nothing expected (cycle %0d)", bus.m_data, cyc);
            end else begin
                d = pend.pop_front();
                l = exp_last.pop_front();
                chk_eq("m_data", bus.m_data, d);
                chk_eq("m_last", bus.m_last, l);
                got_data.push_back(bus.m_data);
                got_last.push_back(bus.m_last);
                got_cyc.push_back(cyc);
            end
        end
        if (bus.rd_en) begin
            rd_cycles.push_back(cyc);
            if (fq.size() > 0) begin
                nxt_out = fq.pop_front();
                nxt_out_v = 1;
                pend.push_back(nxt_out);
            end else nxt_out_v = 0;
        end else nxt_out_v = 0;
        was_idle = !m_busy;
        if (exp_rd) m_issued++;
        if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) m_busy = 0;
        end
        if (pop && l) fin_cnt = 1;
        if (was_idle) begin
            ln = 0;
            if (n >= BL) ln = BL;
            else if (flush_r || (!bus.buf_empty && m_timer == TO - 1)) ln = n;
            if (ln > 0) begin
                m_busy = 1; m_len = ln; m_issued = 0; m_timer = 0; start_cyc = cyc + 1;
                for (int i = 0; i < ln; i++) exp_last.push_back(i == ln - 1);
            end else if (bus.buf_empty) m_timer = 0;
            else if (m_timer < TO) m_timer++;
        end
        prev_rd    = bus.rd_en;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        cyc++;
    endtask

    task automatic step();
        drive();
        #1;
        cycle_check();
        @(negedge clk_r);
    endtask

    task automatic clear_rec();
        got_data.delete(); got_last.delete(); got_cyc.delete(); rd_cycles.delete(); want.delete();
    endtask

    task automatic wait_idle(input int maxc, input int mode);
        bit done = 0;
        for (int k = 0; k < maxc && !done; k++) begin
            ready_r = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : ($urandom_range(0, 99) < 60);
            step();
            if (!m_busy && fq.size() == 0 && pend.size() == 0 && exp_last.size() == 0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: not idle after %0d cycles", maxc);
        end
    endtask

    task automatic check_burst(input string name);
        chk_eq({name, "_count"}, got_data.size(), want.size());
        for (int i = 0; i < want.size() && i < got_data.size(); i++) begin
            chk_eq({name, "_data"}, got_data[i], want[i]);
            chk_eq({name, "_last"}, got_last[i], (i == want.size() - 1));
        end
    endtask

    initial begin
        int load_cyc, fl_cyc;
        logic [DW-1:0] w;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive(); #1;
        chk_eq("reset_rd_en", bus.rd_en, 0);
        chk_eq("reset_m_valid", bus.m_valid, 0);
        chk_eq("reset_m_last", bus.m_last, 0);
        chk_eq("reset_m_data", bus.m_data, 0);
        chk_eq("reset_busy", bus.busy, 0);
        cycle_check();
        @(negedge clk_r);
        step();

        // Full burst with m_ready held high.
        clear_rec();
        for (int i = 0; i < 8; i++) begin w = DW'(i); fq.push_back(w); want.push_back(w); end
        wait_idle(60, 0);
        check_burst("t2");
        chk_eq("t2_rd_count", rd_cycles.size(), 8);
        if (rd_cycles.size() == 8) chk_eq("t2_rd_span", rd_cycles[7] - rd_cycles[0], 7);
        if (got_cyc.size() == 8) begin
            chk_eq("t2_out_span", got_cyc[7] - got_cyc[0], 7);
            chk_eq("t2_latency", got_cyc[0] - rd_cycles[0], 2);
        end

        // Alternating backpressure.
        clear_rec();
        for (int i = 0; i < 8; i++) begin w = DW'($urandom); fq.push_back(w); want.push_back(w); end
        wait_idle(80, 1);
        check_burst("t3");
        chk_eq("t3_rd_count", rd_cycles.size(), 8);

        // Partial backlog ages into a timeout burst.
        clear_rec();
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 8'h32 : (i == 1) ? 8'h1D : 8'h3D;
            fq.push_back(w); want.push_back(w);
        end
        load_cyc = cyc;
        wait_idle(80, 0);
        check_burst("t4");
        chk_eq("t4_rd_count", rd_cycles.size(), 3);
        if (rd_cycles.size() > 0) chk_eq("t4_wait", rd_cycles[0] - load_cyc, 16);

        // Flush drains a partial backlog immediately.
        clear_rec();
        for (int i = 0; i < 5; i++) begin w = DW'($urandom); fq.push_back(w); want.push_back(w); end
        step(); step(); step();
        flush_r = 1'b1;
        fl_cyc = cyc;
        step();
        flush_r = 1'b0;
        wait_idle(60, 0);
        check_burst("t5");
        if (rd_cycles.size() > 0) chk_eq("t5_start", rd_cycles[0], fl_cyc + 1);
        for (int i = 0; i < 10; i++) step();
        chk_eq("t5_idle_after", bus.busy, 0);

        // Underrun: counter claims a full burst but only 4 words are present.
        clear_rec();
        for (int i = 0; i < 4; i++) begin w = DW'($urandom); fq.push_back(w); want.push_back(w); end
        cnt_ovr = 8;
        ready_r = 1'b1;
        step();
        cnt_ovr = -1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk_eq("t6_busy_gap", bus.busy, 1);
        end
        chk_eq("t6_rd_before_refill", rd_cycles.size(), 4);
        for (int i = 0; i < 4; i++) begin w = DW'($urandom); fq.push_back(w); want.push_back(w); end
        wait_idle(60, 0);
        check_burst("t6");
        chk_eq("t6_rd_count", rd_cycles.size(), 8);

        // Reset in the middle of a stalled burst.
        clear_rec();
        for (int i = 0; i < 8; i++) begin w = DW'($urandom); fq.push_back(w); end
        ready_r = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ready_r = 1'b1;
        drive(); #1;
        chk_eq("t1_rd_en", bus.rd_en, 0);
        chk_eq("t1_m_valid", bus.m_valid, 0);
        chk_eq("t1_busy", bus.busy, 0);
        cycle_check();
        @(negedge clk_r);
        clear_rec();
        foreach (fq[i]) want.push_back(fq[i]);
        wait_idle(80, 0);
        check_burst("t1");

        // Randomized traffic, backpressure and flush pulses.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 30 && fq.size() < 60) fq.push_back(DW'($urandom));
            ready_r = ($urandom_range(0, 99) < 70);
            flush_r = ($urandom_range(0, 99) < 3);
            step();
        end
        flush_r = 1'b0;
        wait_idle(500, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
